my_addsub_seq: RTL
==================

// Module: my_addsub_seq
// PURPOSE
//   Parametrised multi-cycle adder/subtractor. It is the successor to the fixed 16-bit ripple adder.
//   - Processes CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
//   - Valid/ready handshakes on both input and output.
//   - Adds subtract mode, carry/borrow in, carry out and signed-overflow flag.
//   - Sits in the ALU datapath where area matters more than single-cycle latency.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; bit 0 is the LSB
//   CHUNK  4   bits processed per cycle; WIDTH % CHUNK must be 0 (elaboration $error otherwise)
//   (derived) NCHUNK = WIDTH/CHUNK; chunk index counter is $clog2(NCHUNK)+1 bits
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands/mode presented
//   in_ready   out  1      block can accept an operation
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      0: a+b+cin; 1: a-b-cin (computed as a + ~b + ~cin)
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1; in sub mode 1 = no borrow
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async assert, sync-released): state=IDLE. in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. Chunk counter=0, carry=0.
//   - FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE); out_valid = (state==DONE).
//   - IDLE: on in_valid, latch a, b^{WIDTH{sub}}, and carry = cin^sub; clear counter; go to RUN.
//     Inputs are sampled only at this edge; later changes are ignored.
//   - RUN: each cycle adds chunk k of A, B and carry into sum[k*CHUNK +: CHUNK], then registers the new carry and k++.
//     After chunk NCHUNK-1: cout=final carry, ovf=carry into bit WIDTH-1 XOR cout; go to DONE.
//   - Latency: out_valid rises exactly NCHUNK cycles after the accepting edge.
//     CHUNK==WIDTH gives 1 cycle.
//   - DONE: sum/cout/ovf held stable while out_valid=1. Leave to IDLE on out_valid&&out_ready.
//     No same-cycle re-accept; max throughput is one op per NCHUNK+2 cycles.
//   - in_valid outside IDLE is ignored (not queued); upstream must hold it until in_ready.
//   - sum bits may change during RUN (partial results). They are valid only while out_valid=1.
//   - rst_n low mid-RUN or in DONE aborts the operation; the result is lost and every output returns to its reset value.
//   - Wrap-around: results are truncated to WIDTH bits; the overflow information is carried only in cout/ovf.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//   1. add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; out_valid exactly 4 cycles after accept.
//   2. add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; then 0x1234+0x0FFF, cin=1 -> 0x2234, cout=0.
//   3. sub 0x0003-0x0005, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
//   4. out_ready low 5 cycles in DONE -> out_valid/sum/cout/ovf stable, in_ready=0, a pulsed in_valid is ignored.
//      After the handshake, in_ready=1 the next cycle.
//   5. rst_n low after 2 RUN cycles -> all outputs at reset values immediately.
//      After release, a new op 0x0001+0x0001 gives 0x0002.
//   6. 10k random ops vs a golden model for (CHUNK=1, 4, 16) and WIDTH=32/CHUNK=8.
//      Random in_valid/out_ready stalls; results, flags and latency must match.

Source files
------------

// File: rtl/my_addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, with a
// registered carry between chunks and valid/ready handshakes on both sides.
module my_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("my_addsub_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
  endgenerate

  // Handshake contract: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; valid is never queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK:0]   csum;
  logic             msb_cin;
  logic [WIDTH-1:0] sum_next;

  // Operands shift down each cycle so the current chunk is always in the low
  // bits; results shift in from the top and land in place after NCHUNK steps.
  always_comb begin
    ca       = a_sh[CHUNK-1:0];
    cb       = b_sh[CHUNK-1:0];
    csum     = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    msb_cin  = ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1];
    sum_next = (sum >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~borrow, so fold the inversion in here.
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{sub}};
            carry    <= cin ^ sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= csum[CHUNK];
          sum   <= sum_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout      <= csum[CHUNK];
            ovf       <= msb_cin ^ csum[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
